// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared definitions for the register-file dump sequencer.
//   dumpState_e  : sequencer states
//   *_DEF        : default geometry of the architectural register file
package reg_dump_pkg;

  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned DATA_W_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2,
    FINISH  = 2'd3
  } dumpState_e;

endpackage

// File: rtl/reg_dump_if.sv
// reg_dump_if: valid/ready stream of (index, data) register dump entries.
//   dump_valid  : entry present
//   dump_ready  : sink accepts entry when dump_valid && dump_ready
//   dump_index  : register index of the entry
//   dump_data   : captured register value
//   master modport = producer (reg_dump_reader), slave modport = trace sink
interface reg_dump_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);

  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_index;
  logic [DATA_W-1:0] dump_data;

  modport master (
    output dump_valid,
    output dump_index,
    output dump_data,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_index,
    input  dump_data,
    output dump_ready
  );

endinterface

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: on a start pulse walks register indices 0..NUM_REGS-1 through
// a combinational register-file read port and streams (index, data) pairs to a
// trace sink over a valid/ready handshake.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : 1-cycle dump request, honoured only in IDLE
//   abort         : synchronous cancel, wins over every other event
//   busy          : high from start acceptance until the cycle before done
//   done          : 1-cycle pulse after the last entry handshakes
//   rf_read_reg   : registered read address to the register file
//   rf_read_data  : register-file data for rf_read_reg (same cycle)
//   dump          : reg_dump_if.master entry stream
// Build option:
//   REG_DUMP_SKIP_ZERO_EN : registers reading as zero are not emitted; the walk
//                           advances directly to the next index.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_read_reg,
  input  logic [DATA_W-1:0] rf_read_data,
  reg_dump_if.master        dump
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dumpState_e        state;
  logic [ADDR_W-1:0] regIdx;

  // The walk counter is itself the registered read address.
  assign rf_read_reg = regIdx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      regIdx          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      dump.dump_valid <= 1'b0;
      dump.dump_index <= '0;
      dump.dump_data  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            regIdx <= '0;
            busy   <= 1'b1;
            state  <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
`ifdef REG_DUMP_SKIP_ZERO_EN
            if (rf_read_data == '0) begin
              if (regIdx == LAST_IDX) begin
                state <= FINISH;
              end else begin
                regIdx <= regIdx + ADDR_W'(1);
              end
            end else begin
              dump.dump_data  <= rf_read_data;
              dump.dump_index <= regIdx;
              dump.dump_valid <= 1'b1;
              state           <= SEND;
            end
`else
            dump.dump_data  <= rf_read_data;
            dump.dump_index <= regIdx;
            dump.dump_valid <= 1'b1;
            state           <= SEND;
`endif
          end
        end

        SEND: begin
          // A handshake coinciding with abort still delivers the entry; only
          // the continuation is cancelled.
          if (abort) begin
            dump.dump_valid <= 1'b0;
            busy            <= 1'b0;
            state           <= IDLE;
          end else if (dump.dump_ready) begin
            dump.dump_valid <= 1'b0;
            if (regIdx == LAST_IDX) begin
              state <= FINISH;
            end else begin
              regIdx <= regIdx + ADDR_W'(1);
              state  <= CAPTURE;
            end
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          done  <= !abort;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

  localparam int unsigned NR = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
`ifdef REG_DUMP_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] rfReadReg;
  logic [DW-1:0] rfReadData;
  logic [DW-1:0] regFile [NR];

  reg_dump_if #(.ADDR_W(AW), .DATA_W(DW)) dumpBus ();

  assign rfReadData = regFile[rfReadReg];

  reg_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .rf_read_reg  (rfReadReg),
    .rf_read_data (rfReadData),
    .dump         (dumpBus.master)
  );

  always #5 clk = ~clk;

  entry_t sb [$];
  int     total = 0;
  int     bad = 0;
  int     doneCnt = 0;
  int     entryCnt = 0;
  entry_t heldE;
  bit     holding = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected entries for register indices lo..hi given the current file contents.
  task automatic pushRange(input int unsigned lo, input int unsigned hi, output int unsigned n);
    n = 0;
    for (int unsigned i = lo; i <= hi; i++) begin
      if (!SKIP || regFile[i] != '0) begin
        sb.push_back('{idx: AW'(i), data: regFile[i]});
        n++;
      end
    end
  endtask

  // Scoreboard consumer and hold-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    entry_t e;
    if (!rst_n) begin
      holding = 1'b0;
    end else begin
      if (done) doneCnt++;
      if (holding && dumpBus.dump_valid)
        check("holdStable", {dumpBus.dump_index, dumpBus.dump_data}, heldE);
      holding = 1'b0;
      if (dumpBus.dump_valid && !dumpBus.dump_ready) begin
        holding = 1'b1;
        heldE   = '{idx: dumpBus.dump_index, data: dumpBus.dump_data};
      end
      if (dumpBus.dump_valid && dumpBus.dump_ready) begin
        if (sb.size() == 0) begin
          check("extraEntry", {dumpBus.dump_index, dumpBus.dump_data}, '1);
        end else begin
          e = sb.pop_front();
          check("entry", {dumpBus.dump_index, dumpBus.dump_data}, e);
          entryCnt++;
        end
      end
    end
  end

  // Run from the current state until done is seen or the budget expires.
  task automatic waitDone(input bit randReady, input int unsigned budget, output int unsigned cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (randReady) dumpBus.dump_ready = 1'($urandom_range(0, 1));
    end while (!done && cyc < budget);
    if (!done) check("doneTimeout", done, 1);
  endtask

  initial begin
    int unsigned n;
    int unsigned cyc;
    int unsigned firstValid;
    int          d0;
    int          e0;

    dumpBus.dump_ready = 1'b0;
    for (int unsigned i = 0; i < NR; i++) regFile[i] = '0;

    // Reset state
    tick();
    tick();
    check("rstBusy", busy, 0);
    check("rstDone", done, 0);
    check("rstValid", dumpBus.dump_valid, 0);
    check("rstReadReg", rfReadReg, 0);
    rst_n = 1'b1;
    tick();

    // start and abort together in IDLE: stays idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("startAbortBusy", busy, 0);
    tick();
    check("startAbortValid", dumpBus.dump_valid, 0);

    // 1: ordered dump, ready high, cycle-exact latency
    for (int unsigned i = 0; i < NR; i++) regFile[i] = DW'(i * 32'h11);
    pushRange(0, NR - 1, n);
    d0 = doneCnt;
    e0 = entryCnt;
    dumpBus.dump_ready = 1'b1;
    start = 1'b1;
    cyc = 0;
    firstValid = 0;
    do begin
      tick();
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check("busyOnAccept", busy, 1);
      end
      if (dumpBus.dump_valid && firstValid == 0) firstValid = cyc;
    end while (!done && cyc < 300);
    check("t1done", done, 1);
`ifndef REG_DUMP_SKIP_ZERO_EN
    check("t1firstValidCyc", firstValid, 2);
    check("t1doneCyc", cyc, 2 * NR + 2);
`endif
    check("t1busyAtDone", busy, 0);
    tick();
    check("t1donePulse", done, 0);
    check("t1doneCnt", doneCnt - d0, 1);
    check("t1entries", entryCnt - e0, n);
    check("t1sbEmpty", sb.size(), 0);

    // 2: random back-pressure, random data
    for (int unsigned i = 0; i < NR; i++) regFile[i] = $urandom() | 32'h1;
    pushRange(0, NR - 1, n);
    d0 = doneCnt;
    e0 = entryCnt;
    dumpBus.dump_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(1'b1, 2000, cyc);
    tick();
    check("t2doneCnt", doneCnt - d0, 1);
    check("t2entries", entryCnt - e0, n);
    check("t2sbEmpty", sb.size(), 0);

    // 3: abort while entry 9 waits in SEND
    for (int unsigned i = 0; i < NR; i++) regFile[i] = DW'(i * 32'h11);
    pushRange(0, 8, n);
    d0 = doneCnt;
    e0 = entryCnt;
    dumpBus.dump_ready = 1'b0;
    start = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      start = 1'b0;
      dumpBus.dump_ready = dumpBus.dump_valid && dumpBus.dump_index < AW'(9);
    end while (!(dumpBus.dump_valid && dumpBus.dump_index == AW'(9)) && cyc < 200);
    check("t3reachIdx9", dumpBus.dump_index, 9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3abortValid", dumpBus.dump_valid, 0);
    check("t3abortBusy", busy, 0);
    repeat (4) tick();
    check("t3noDone", doneCnt - d0, 0);
    check("t3entries", entryCnt - e0, n);
    check("t3sbEmpty", sb.size(), 0);
    // restart walks from index 0 again
    pushRange(0, NR - 1, n);
    e0 = entryCnt;
    dumpBus.dump_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(1'b0, 300, cyc);
    tick();
    check("t3restartEntries", entryCnt - e0, n);
    check("t3restartDone", doneCnt - d0, 1);

    // 4: asynchronous reset while entry 5 is presented
    pushRange(0, 4, n);
    d0 = doneCnt;
    e0 = entryCnt;
    dumpBus.dump_ready = 1'b0;
    start = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      start = 1'b0;
      dumpBus.dump_ready = dumpBus.dump_valid && dumpBus.dump_index < AW'(5);
    end while (!(dumpBus.dump_valid && dumpBus.dump_index == AW'(5)) && cyc < 200);
    check("t4reachIdx5", dumpBus.dump_index, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4rstValid", dumpBus.dump_valid, 0);
    check("t4rstBusy", busy, 0);
    check("t4rstIndex", dumpBus.dump_index, 0);
    check("t4rstData", dumpBus.dump_data, 0);
    check("t4rstReadReg", rfReadReg, 0);
    dumpBus.dump_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t4noDone", doneCnt - d0, 0);
    check("t4entries", entryCnt - e0, n);
    check("t4sbEmpty", sb.size(), 0);

    // 5: start pulses during an active dump are ignored
    pushRange(0, NR - 1, n);
    d0 = doneCnt;
    e0 = entryCnt;
    dumpBus.dump_ready = 1'b1;
    start = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      start = (cyc % 7 == 3) && !done;
    end while (!done && cyc < 300);
    start = 1'b0;
    check("t5done", done, 1);
    repeat (5) tick();
    check("t5doneCnt", doneCnt - d0, 1);
    check("t5entries", entryCnt - e0, n);
    check("t5idleValid", dumpBus.dump_valid, 0);
    check("t5idleBusy", busy, 0);

`ifdef REG_DUMP_SKIP_ZERO_EN
    // 6: zero-valued registers are skipped
    for (int unsigned i = 0; i < NR; i++) regFile[i] = '0;
    regFile[3]  = 32'hDEAD;
    regFile[31] = 32'h1;
    pushRange(0, NR - 1, n);
    check("t6expectTwo", n, 2);
    d0 = doneCnt;
    e0 = entryCnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(1'b0, 300, cyc);
    tick();
    check("t6entries", entryCnt - e0, 2);
    check("t6doneCnt", doneCnt - d0, 1);
    check("t6sbEmpty", sb.size(), 0);
    regFile[3]  = '0;
    regFile[31] = '0;
    d0 = doneCnt;
    e0 = entryCnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(1'b0, 300, cyc);
    tick();
    check("t6zeroEntries", entryCnt - e0, 0);
    check("t6zeroDone", doneCnt - d0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
